alu_exec_stage: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU controller, together with the selected operands.
- Produces a registered result, a zero flag, a branch decision and a signed-overflow flag.
- Most operations take one cycle; SLL is iterative at one bit per cycle.
- Valid/ready handshakes on both sides let the stage stall the upstream decode and tolerate downstream back-pressure.

---
 rtl/alu_exec_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_exec_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle ops plus a bit-serial SLL, with valid/ready
// handshakes on both sides and registered result/flag outputs.
module alu_exec_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [3:0]         ctrl_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               zero_o,
  output logic               branch_o,
  output logic               ovf_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;
  localparam logic [3:0] OP_ORI  = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                zero_q, zero_d;
  logic                branch_q, branch_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;

  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   op_res;
  logic                op_br;
  logic                op_ovf;
  logic                accept;
  logic                sll_start;

  // Single-cycle datapath; SLL here only covers the zero-shift case
  always_comb begin
    sum    = src1_i + src2_i;
    diff   = src1_i - src2_i;
    op_res = '0;
    op_br  = 1'b0;
    op_ovf = 1'b0;
    case (ctrl_i)
      OP_ADD: begin
        op_res = sum;
        op_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                 (sum[DATA_W-1] != src1_i[DATA_W-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                 (diff[DATA_W-1] != src1_i[DATA_W-1]);
      end
      OP_AND:  op_res = src1_i & src2_i;
      OP_OR:   op_res = src1_i | src2_i;
      OP_ORI:  op_res = src1_i | src2_i;
      OP_SLT:  op_res = DATA_W'($signed(src1_i) < $signed(src2_i));
      OP_SLTU: op_res = DATA_W'(src1_i < src2_i);
      OP_SLL:  op_res = src2_i;
      OP_LUI:  op_res = src2_i << 16;
      OP_BEQ: begin
        op_res = diff;
        op_br  = (diff == '0);
      end
      OP_BNE: begin
        op_res = diff;
        op_br  = (diff != '0);
      end
      default: op_res = '0;
    endcase
  end

  assign in_ready_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign sll_start  = (ctrl_i == OP_SLL) && (shamt_i != '0);

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    branch_d = branch_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = ST_DONE;
          result_d = shreg_q << 1;
          zero_d   = ((shreg_q << 1) == '0);
          branch_d = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready_i && !in_valid_i) state_d = ST_IDLE;
      end
      default: state_d = state_q;
    endcase

    // A new op overrides the DONE->IDLE drain in the same edge
    if (accept) begin
      if (sll_start) begin
        state_d = ST_SHIFT;
        shreg_d = src2_i;
        cnt_d   = shamt_i;
      end else begin
        state_d  = ST_DONE;
        result_d = op_res;
        zero_d   = (op_res == '0);
        branch_d = op_br;
        ovf_d    = op_ovf;
      end
    end

    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      branch_q    <= branch_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign branch_o    = branch_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_exec_stage;

  logic        clk_i;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        branch_o;
  logic        ovf_o;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ctrl_i(ctrl_i), .src1_i(src1_i), .src2_i(src2_i), .shamt_i(shamt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .zero_o(zero_o), .branch_o(branch_o), .ovf_o(ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: overflow means the exact integer result differs from the wrapped one
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r,
                                output logic br, output logic ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; br = 1'b0; ov = 1'b0; s = 0;
    case (c)
      4'd0: begin r = a + b; s = sa + sb; ov = (s != longint'($signed(r))); end
      4'd1: begin r = a - b; s = sa - sb; ov = (s != longint'($signed(r))); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: r = (a < b) ? 32'd1 : 32'd0;
      4'd6: r = b << sh;
      4'd7: r = b * 32'd65536;
      4'd8: r = a | b;
      4'd9: begin r = a - b; br = (a == b); end
      4'd10: begin r = a - b; br = (a != b); end
      default: r = 32'd0;
    endcase
  endfunction

  // Issue one op, then wait for its result; lat counts negedges until out_valid_o
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int lat, output int rdy_low);
    int n;
    @(negedge clk_i);
    ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh; in_valid_i = 1'b1;
    #1;
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk_i); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready_o never rose for ctrl %0d", c);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    src1_i = $urandom; src2_i = $urandom; shamt_i = 5'($urandom); ctrl_i = 4'($urandom);
    lat = 1; rdy_low = 0;
    while (!out_valid_o && lat < 200) begin
      if (!in_ready_o) rdy_low++;
      @(negedge clk_i); lat++;
    end
    if (!out_valid_o) begin
      checks++; errors++;
      $display("FAIL result_timeout: out_valid_o never rose for ctrl %0d", c);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    ctrl_i = 4'd0; src1_i = 32'd0; src2_i = 32'd0; shamt_i = 5'd0;
    #2;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
    checks++; if ({zero_o, branch_o, ovf_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {zero_o, branch_o, ovf_o}); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_add_ovf();
    int lat, rl;
    out_ready_i = 1'b1;
    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, lat, rl);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    checks++; if (result_o !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %h want 80000000", result_o); end
    checks++; if ({ovf_o, zero_o, branch_o} !== 3'b100) begin errors++; $display("FAIL add_flags: got ovf/zero/br %b want 100", {ovf_o, zero_o, branch_o}); end
    @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL add_drain: out_valid got %b want 0", out_valid_o); end
    checks++; if (result_o !== 32'h8000_0000) begin errors++; $display("FAIL add_hold: got %h want 80000000", result_o); end
  endtask

  task automatic test_sll();
    int lat, rl;
    run_op(4'd6, 32'h3, 32'h3, 5'd4, lat, rl);
    checks++; if (rl !== 4) begin errors++; $display("FAIL sll_ready_low: got %0d cycles want 4", rl); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sll_latency: valid at negedge %0d want 5", lat); end
    checks++; if (result_o !== 32'h30) begin errors++; $display("FAIL sll_result: got %h want 00000030", result_o); end
    run_op(4'd6, 32'h0, 32'h3, 5'd0, lat, rl);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sll0_latency: got %0d want 1", lat); end
    checks++; if (result_o !== 32'h3) begin errors++; $display("FAIL sll0_result: got %h want 00000003", result_o); end
  endtask

  task automatic test_branch();
    int lat, rl;
    run_op(4'd9, 32'd5, 32'd5, 5'd0, lat, rl);
    checks++; if ({branch_o, zero_o} !== 2'b11) begin errors++; $display("FAIL beq_eq: br/zero got %b want 11", {branch_o, zero_o}); end
    run_op(4'd10, 32'd5, 32'd5, 5'd0, lat, rl);
    checks++; if (branch_o !== 1'b0) begin errors++; $display("FAIL bne_eq: br got %b want 0", branch_o); end
    run_op(4'd10, 32'd5, 32'd6, 5'd0, lat, rl);
    checks++; if (branch_o !== 1'b1) begin errors++; $display("FAIL bne_ne: br got %b want 1", branch_o); end
    checks++; if (result_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bne_result: got %h want ffffffff", result_o); end
  endtask

  task automatic test_compare();
    int lat, rl;
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, rl);
    checks++; if (result_o !== 32'd1) begin errors++; $display("FAIL slt: got %h want 1", result_o); end
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd0, lat, rl);
    checks++; if (result_o !== 32'd0 || zero_o !== 1'b1) begin errors++; $display("FAIL sltu: got %h z=%b want 0 z=1", result_o, zero_o); end
    run_op(4'd7, 32'd0, 32'h1234, 5'd0, lat, rl);
    checks++; if (result_o !== 32'h1234_0000) begin errors++; $display("FAIL lui: got %h want 12340000", result_o); end
    run_op(4'd13, 32'h55, 32'hAA, 5'd0, lat, rl);
    checks++; if (result_o !== 32'd0 || {zero_o, branch_o, ovf_o} !== 3'b100) begin errors++; $display("FAIL reserved: got %h flags %b want 0 flags 100", result_o, {zero_o, branch_o, ovf_o}); end
  endtask

  task automatic test_back_to_back();
    int lat, rl;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    run_op(4'd0, 32'd2, 32'd3, 5'd0, lat, rl);
    checks++; if (result_o !== 32'd5) begin errors++; $display("FAIL bp_first: got %h want 5", result_o); end
    ctrl_i = 4'd3; src1_i = 32'hF0; src2_i = 32'h0F; shamt_i = 5'd0; in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== 32'd5 || in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b result=%h ready=%b want 1/5/0", i, out_valid_o, result_o, in_ready_o);
      end
    end
    out_ready_i = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b want 1", in_ready_o); end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || result_o !== 32'hFF) begin errors++; $display("FAIL bp_swap: valid=%b result=%h want 1/ff", out_valid_o, result_o); end
    @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: valid got %b want 0", out_valid_o); end
  endtask

  task automatic test_reset_mid_shift();
    int lat, rl, seen;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    ctrl_i = 4'd6; src1_i = 32'd0; src2_i = 32'd1; shamt_i = 5'd31; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (8) @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin errors++; $display("FAIL mid_shift: valid=%b ready=%b want 0/0", out_valid_o, in_ready_o); end
    rst_i = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL async_reset: valid=%b result=%h zero=%b ready=%b want 0/0/0/1", out_valid_o, result_o, zero_o, in_ready_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (out_valid_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_abort: out_valid seen %0d cycles want 0", seen); end
    run_op(4'd0, 32'd1, 32'd1, 5'd0, lat, rl);
    checks++; if (result_o !== 32'd2 || lat !== 1) begin errors++; $display("FAIL post_reset_add: result=%h lat=%0d want 2/1", result_o, lat); end
  endtask

  task automatic test_random();
    int lat, rl, k, exp_lat;
    logic [3:0]  c;
    logic [31:0] a, b, er;
    logic [4:0]  sh;
    logic        ebr, eov;
    for (int it = 0; it < 60; it++) begin
      c  = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      sh = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0: b = a;
        1: a = 32'h7FFF_FFFF;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      model(c, a, b, sh, er, ebr, eov);
      exp_lat = (c == 4'd6 && sh != 5'd0) ? int'(sh) + 1 : 1;
      run_op(c, a, b, sh, lat, rl);
      checks++;
      if (result_o !== er || zero_o !== (er == 32'd0) || branch_o !== ebr || ovf_o !== eov) begin
        errors++;
        $display("FAIL rand_op%0d ctrl=%0d a=%h b=%h sh=%0d: got %h z%b b%b o%b want %h z%b b%b o%b",
                 it, c, a, b, sh, result_o, zero_o, branch_o, ovf_o, er, (er == 32'd0), ebr, eov);
      end
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL rand_lat%0d ctrl=%0d: got %0d want %0d", it, c, lat, exp_lat); end
      k = $urandom_range(0, 3);
      if (k != 0) begin
        out_ready_i = 1'b0;
        repeat (k) @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== er) begin
          errors++; $display("FAIL rand_stall%0d: valid=%b result=%h want 1/%h", it, out_valid_o, result_o, er);
        end
        out_ready_i = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sll();
    test_branch();
    test_compare();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
